// File: rtl/env_amp.sv
// Envelope/gain amplifier: multiplies a Q2.14 sample by the ADSR envelope and a gain,
// then clips to [-1.0, +1.0] through a two-stage stall-able pipeline.
module env_amp #(
    parameter int unsigned W    = 16,
    parameter int unsigned FRAC = 14,
    parameter int unsigned SCW  = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           s_valid,
    output logic           s_ready,
    input  logic [W-1:0]   s_data,
    input  logic [W-1:0]   env,
    input  logic [W-1:0]   gain,
    output logic           m_valid,
    input  logic           m_ready,
    output logic [W-1:0]   m_data,
    input  logic           clr_sat,
    output logic [SCW-1:0] sat_cnt
);

    localparam int unsigned P1Width = W + 3;
    localparam int unsigned P2Width = W + 6;
    localparam int unsigned M1Width = 2 * W + 1;
    localparam int unsigned M2Width = P1Width + W + 1;

    localparam logic signed [M1Width-1:0] Round1 = M1Width'(1) << (FRAC - 1);
    localparam logic signed [M2Width-1:0] Round2 = M2Width'(1) << (FRAC - 1);
    localparam logic signed [P2Width-1:0] ClipHi = P2Width'(1) << FRAC;
    localparam logic signed [P2Width-1:0] ClipLo = -ClipHi;

    logic                      v1_q, v2_q;
    logic signed [P1Width-1:0] p1_q;
    logic [W-1:0]              gain_q;
    logic [W-1:0]              m_data_q;
    logic [SCW-1:0]            sat_cnt_q, sat_cnt_d;

    logic                      en, accept;
    logic signed [M1Width-1:0] prod1;
    logic signed [P1Width-1:0] p1_d;
    logic signed [M2Width-1:0] prod2;
    logic signed [P2Width-1:0] p2;
    logic [W-1:0]              clip_d;
    logic                      sat_d, sat_inc;

    always_comb begin
        en     = !v2_q || m_ready;
        accept = s_valid && en;

        // Envelope and gain are unsigned, so widen with a zero MSB before the signed multiply.
        prod1 = $signed(s_data) * $signed({1'b0, env});
        p1_d  = P1Width'((prod1 + Round1) >>> FRAC);

        prod2 = p1_q * $signed({1'b0, gain_q});
        p2    = P2Width'((prod2 + Round2) >>> FRAC);

        sat_d  = 1'b0;
        clip_d = W'(p2);
        if (p2 > ClipHi) begin
            sat_d  = 1'b1;
            clip_d = W'(ClipHi);
        end else if (p2 < ClipLo) begin
            sat_d  = 1'b1;
            clip_d = W'(ClipLo);
        end

        // Count on the stage-2 load of a valid sample, not on the output handshake.
        sat_inc = en && v1_q && sat_d;

        sat_cnt_d = sat_cnt_q;
        if (clr_sat) begin
            sat_cnt_d = sat_inc ? SCW'(1) : '0;
        end else if (sat_inc && (sat_cnt_q != '1)) begin
            sat_cnt_d = sat_cnt_q + SCW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            p1_q      <= '0;
            gain_q    <= '0;
            m_data_q  <= '0;
            sat_cnt_q <= '0;
        end else begin
            if (en) begin
                v1_q     <= accept;
                v2_q     <= v1_q;
                m_data_q <= clip_d;
                if (accept) begin
                    p1_q   <= p1_d;
                    gain_q <= gain;
                end
            end
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign s_ready = en;
    assign m_valid = v2_q;
    assign m_data  = m_data_q;
    assign sat_cnt = sat_cnt_q;

endmodule

// File: tb/tb_env_amp.sv
// Bench for env_amp: directed steps plus random traffic, scored against an integer
// arithmetic model of the scale/round/clip rules.
module tb_env_amp;

    localparam int SCW_TB = 4;
    localparam int SAT_MAX = (1 << SCW_TB) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              s_valid;
    logic              s_ready;
    logic [15:0]       s_data;
    logic [15:0]       env;
    logic [15:0]       gain;
    logic              m_valid;
    logic              m_ready;
    logic [15:0]       m_data;
    logic              clr_sat;
    logic [SCW_TB-1:0] sat_cnt;

    env_amp #(.W(16), .FRAC(14), .SCW(SCW_TB)) dut (
        .clk     (clk),
        .reset   (reset),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .env     (env),
        .gain    (gain),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .clr_sat (clr_sat),
        .sat_cnt (sat_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        bit          sat;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] out_log[$];
    int          checks = 0;
    int          errors = 0;
    int          sat_model = 0;
    bit          acc;
    bit          prev_stall = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: exact integer products, floor shift of (x + half), then clip to +-1.0.
    function automatic exp_t ref_out(input logic [15:0] s, input logic [15:0] e,
                                     input logic [15:0] g);
        exp_t        r;
        longint      sv, ev, gv, p1, p2;
        logic [63:0] bits;
        sv = longint'($signed(s));
        ev = longint'(e);
        gv = longint'(g);
        p1 = (sv * ev + 8192) >>> 14;
        p2 = (p1 * gv + 8192) >>> 14;
        r.sat = 1'b1;
        if (p2 > 16384)       r.data = 16'h4000;
        else if (p2 < -16384) r.data = 16'hC000;
        else begin
            bits   = p2;
            r.data = bits[15:0];
            r.sat  = 1'b0;
        end
        return r;
    endfunction

    task automatic tick();
        exp_t e;
        @(negedge clk);
        acc = 1'b0;
        if (reset) begin
            check("s_ready", s_ready, !m_valid || m_ready);
            if (prev_stall) check("hold_valid", m_valid, 1);
            if (m_valid) begin
                check("out_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    check("m_data", m_data, exp_q[0].data);
                    if (m_ready) begin
                        e = exp_q.pop_front();
                        out_log.push_back(m_data);
                        if (e.sat && sat_model < SAT_MAX) sat_model++;
                    end
                end
            end
            prev_stall = m_valid && !m_ready;
            acc = s_valid && s_ready;
            if (acc) exp_q.push_back(ref_out(s_data, env, gain));
            if (clr_sat) sat_model = 0;
        end else begin
            prev_stall = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] s, input logic [15:0] e, input logic [15:0] g);
        s_valid = 1'b1;
        s_data  = s;
        env     = e;
        gain    = g;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (acc) break;
        end
        if (!acc) begin
            errors++;
            $display("FAIL send_timeout: observed no accept, required accept within 100 cycles");
        end
        s_valid = 1'b0;
    endtask

    task automatic drain();
        m_ready = 1'b1;
        s_valid = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (exp_q.size() == 0 && !m_valid) break;
            tick();
        end
        check("drained", exp_q.size(), 0);
        check("sat_cnt", sat_cnt, sat_model);
    endtask

    initial begin
        int base;
        int idx;
        reset   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        env     = '0;
        gain    = '0;
        m_ready = 1'b1;
        clr_sat = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 16'h0000);
        check("rst_sat_cnt", sat_cnt, 0);
        check("rst_s_ready", s_ready, 1);

        // Unity path and two-cycle latency
        send(16'h2000, 16'h4000, 16'h4000);
        check("lat_c1_valid", m_valid, 0);
        tick();
        check("lat_c2_valid", m_valid, 1);
        check("lat_c2_data", m_data, 16'h2000);
        drain();
        check("unity_out", out_log[$], 16'h2000);
        check("unity_sat", sat_cnt, 0);

        // Positive and negative clipping, then clear
        send(16'h3000, 16'h4000, 16'h8000);
        drain();
        check("clip_pos", out_log[$], 16'h4000);
        check("clip_pos_cnt", sat_cnt, 1);
        send(16'hC000, 16'h4000, 16'h8000);
        drain();
        check("clip_neg", out_log[$], 16'hC000);
        check("clip_neg_cnt", sat_cnt, 2);
        clr_sat = 1'b1;
        tick();
        clr_sat = 1'b0;
        check("clr_cnt", sat_cnt, 0);

        // Rounding half toward +inf
        send(16'h0001, 16'h2000, 16'h4000);
        drain();
        check("round_pos", out_log[$], 16'h0001);
        send(16'hFFFF, 16'h2000, 16'h4000);
        drain();
        check("round_neg", out_log[$], 16'h0000);

        // Stream of 8 with a 4-cycle downstream stall
        base = out_log.size();
        idx  = 0;
        env  = 16'h4000;
        gain = 16'h4000;
        for (int k = 0; k < 40 && idx < 8; k++) begin
            m_ready = (k < 3 || k > 6);
            s_valid = 1'b1;
            s_data  = 16'((idx + 1) << 8);
            tick();
            if (acc) idx++;
        end
        drain();
        check("stream_count", out_log.size() - base, 8);
        for (int i = 0; i < 8 && base + i < out_log.size(); i++)
            check("stream_order", out_log[base + i], 32'((i + 1) << 8));

        // Envelope drops to zero right after an accept
        send(16'h1000, 16'h4000, 16'h4000);
        env = 16'h0000;
        tick();
        send(16'h2000, 16'h0000, 16'h4000);
        send(16'h7FFF, 16'h0000, 16'hFFFF);
        drain();
        check("env_before", out_log[$-2], 16'h1000);
        check("env_zero_a", out_log[$-1], 16'h0000);
        check("env_zero_b", out_log[$], 16'h0000);

        // Clear coinciding with a clipped stage-2 load
        send(16'h3000, 16'h4000, 16'h8000);
        clr_sat = 1'b1;
        tick();
        clr_sat = 1'b0;
        drain();
        check("clr_and_inc", sat_cnt, 1);

        // Random traffic; gain up to ~4.0 drives the counter into its ceiling
        for (int k = 0; k < 400; k++) begin
            s_valid = ($urandom_range(0, 3) != 0);
            s_data  = 16'($urandom);
            env     = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom_range(0, 16'h4000));
            gain    = 16'($urandom);
            m_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();
        check("rand_sat_ceiling", sat_cnt, SAT_MAX);

        // Reset with two samples in flight
        m_ready = 1'b0;
        send(16'h1234, 16'h4000, 16'h4000);
        send(16'h0567, 16'h4000, 16'h4000);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        exp_q.delete();
        sat_model  = 0;
        check("midrst_m_valid", m_valid, 0);
        check("midrst_m_data", m_data, 16'h0000);
        check("midrst_sat_cnt", sat_cnt, 0);
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("midrst_no_stale", m_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
